par2ser_en: RTL and testbench
=============================

Name: par2ser_en

Overview:
- Parallel-to-serial converter with a valid/ready word input.
- Emits one bit per cycle as a data bit plus a bit-enable strobe.
- Sits directly upstream of the team's enable-gated flop stages: ser_d_o drives the flop data input and ser_en_o drives its enable.
- Downstream therefore captures exactly one serial bit per enabled cycle and holds it otherwise.

Parameters:
- DATA_W, 8: parallel word width in bits; must be >= 1.
- LSB_FIRST, 1: 1 = bit 0 shifted out first; 0 = bit DATA_W-1 shifted out first.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- par_data_i  input  DATA_W  word to serialize; sampled only on handshake.
- par_valid_i  input  1  upstream word valid.
- par_ready_o  output  1  block can accept a word this cycle.
- ser_d_o  output  1  current serial bit.
- ser_en_o  output  1  ser_d_o is a valid bit this cycle (downstream enable).
- last_o  output  1  current bit is the final bit of the word.
- busy_o  output  1  a word is being shifted out.

Behaviour:
- Clock and reset
  - One clock domain.
  - reset low forces, asynchronously: state IDLE, shift register 0, bit counter 0.
  - Resulting outputs: ser_d_o=0, ser_en_o=0, last_o=0, busy_o=0, par_ready_o=1.
  - Inputs are ignored while reset is low.
- States: IDLE, SHIFT (2-state FSM, enum in package).
- Handshake
  - Transfer occurs at a rising edge where par_valid_i && par_ready_o.
  - par_ready_o = (state==IDLE) || (state==SHIFT && last_o).
  - par_ready_o depends only on registered state, never combinationally on par_valid_i.
  - Upstream may hold par_valid_i high indefinitely. No word is lost, no word is duplicated.
- IDLE
  - ser_en_o=0 and busy_o=0.
  - On transfer: load par_data_i into the shift register, counter=0, go to SHIFT.
  - No transfer: stay in IDLE.
- SHIFT
  - ser_en_o=1 and busy_o=1 every cycle.
  - ser_d_o = shift register bit 0 (LSB_FIRST=1) or bit DATA_W-1 (LSB_FIRST=0).
  - Each edge: shift by one toward the output bit, counter+1.
  - last_o = (counter==DATA_W-1), qualified by state==SHIFT.
  - On the last-bit edge:
    - with a transfer: reload, counter=0, stay in SHIFT (zero-bubble back-to-back).
    - without a transfer: go to IDLE.
- Latency and throughput
  - Word accepted at edge N: first bit valid on ser_d_o/ser_en_o after edge N, so downstream samples it at edge N+1.
  - Word occupies exactly DATA_W consecutive enabled cycles.
  - Sustained throughput is 1 word per DATA_W cycles.
- Width rules
  - Counter width = max(1, $clog2(DATA_W)); no wrap beyond DATA_W-1.
  - DATA_W=1: every SHIFT cycle is last; par_ready_o stays 1 continuously.
- All outputs are driven from registered state/data only: no combinational input-to-output paths.
- Boundary cases
  - par_valid_i high while busy and not last: no transfer, par_data_i changes are ignored.
  - Reset low mid-word: remaining bits are dropped; ser_en_o falls immediately (asynchronous).
  - After reset release: IDLE, par_ready_o=1; the next word starts clean.

Decomposition:
- Package par2ser_pkg:
  - state enum typedef {IDLE, SHIFT}.
  - Helper function for counter width.
- No sub-module: FSM, counter and shift register stay inline; a sub-module split would be artificial at this size.
- The downstream enable flop is a separate, existing block instantiated by the integrating level, not inside this one.

Test Plan:
1. DATA_W=8, LSB_FIRST=1: one-cycle handshake with 0xA5 at edge 0.
   - ser_d_o = 1,0,1,0,0,1,0,1 on cycles 1-8, ser_en_o=1 on cycles 1-8.
   - last_o only on cycle 8; ser_en_o=0 on cycle 9; par_ready_o=0 on cycles 1-7.
2. LSB_FIRST=0: word 0x1F gives ser_d_o = 0,0,0,1,1,1,1,1. Repeat with LSB_FIRST=1: gives 1,1,1,1,1,0,0,0.
3. Back-to-back: valid held high with 0x0F then 0xF0.
   - 16 consecutive ser_en_o cycles with no gap; bits 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1 (LSB first).
   - par_ready_o=1 on cycles 8 and 16.
4. Valid during busy: accept 0x00, then drive 0x55 with valid=1 from cycle 2.
   - Not accepted until cycle 8 (last); 0x55 bits appear on cycles 9-16.
   - par_data_i changes between cycles 2 and 7 are ignored.
5. Reset mid-word: accept 0xFF, pull reset low after 3 bits.
   - ser_en_o, busy_o and last_o go to 0 immediately without waiting for a clock edge.
   - After release: par_ready_o=1; no residual bits; next word 0x81 serializes correctly.
6. DATA_W=1: stream 1,0,1 with valid held high.
   - ser_en_o=1 for 3 consecutive cycles; last_o=1 each cycle; par_ready_o stays 1.

Source files
------------

// File: rtl/par2ser_pkg.sv
// par2ser_pkg: shared types and helpers for the par2ser_en serializer.
//   state_t   : serializer FSM state (IDLE, SHIFT).
//   cnt_width : bit-counter width for a given word width, never below 1.
package par2ser_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // A one-bit word still needs a one-bit counter so the compare stays legal.
  function automatic int cnt_width(input int data_w);
    if (data_w <= 1) begin
      return 1;
    end else begin
      return $clog2(data_w);
    end
  endfunction

endpackage

// File: rtl/par2ser_en_if.sv
// par2ser_en_if: word input handshake plus serial output bundle.
//   par_data_i  : word to serialize (DATA_W bits)
//   par_valid_i : upstream word valid
//   par_ready_o : serializer can take a word this cycle
//   ser_d_o     : current serial bit (downstream flop D)
//   ser_en_o    : ser_d_o is valid this cycle (downstream flop enable)
//   last_o      : current bit is the final bit of the word
//   busy_o      : a word is being shifted out
// master = upstream/integration side, slave = the serializer.
interface par2ser_en_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] par_data_i;
  logic              par_valid_i;
  logic              par_ready_o;
  logic              ser_d_o;
  logic              ser_en_o;
  logic              last_o;
  logic              busy_o;

  modport master (
    output par_data_i, par_valid_i,
    input  par_ready_o, ser_d_o, ser_en_o, last_o, busy_o
  );

  modport slave (
    input  par_data_i, par_valid_i,
    output par_ready_o, ser_d_o, ser_en_o, last_o, busy_o
  );

endinterface

// File: rtl/par2ser_en.sv
// par2ser_en: parallel-to-serial converter feeding enable-gated flop stages.
// A word is taken on a valid/ready handshake and emitted one bit per cycle on
// ser_d_o with ser_en_o high, for exactly DATA_W consecutive cycles. A new
// word may be accepted on the last-bit edge, giving gap-free back-to-back words.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : par2ser_en_if slave (handshake input, serial outputs)
// Every output is decoded from registers only; nothing passes combinationally
// from an input to an output.
module par2ser_en
  import par2ser_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        reset,
  par2ser_en_if.slave bus
);

  localparam int               CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] shift_nxt_s;
  logic [DATA_W-1:0] shifted_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              last_s;
  logic              ready_s;
  logic              xfer_s;

  // Ready comes from registered state only, so valid can never loop into it.
  assign last_s  = (state_r == SHIFT) && (cnt_r == CNT_LAST);
  assign ready_s = (state_r == IDLE) || last_s;
  assign xfer_s  = bus.par_valid_i && ready_s;

  // Shift toward the output bit; zeros fill in so the register drains to 0.
  always_comb begin
    shifted_s = shift_r;
    if (LSB_FIRST != 0) begin
      shifted_s = shift_r >> 1'b1;
    end else begin
      shifted_s = shift_r << 1'b1;
    end
  end

  // Next-state, next-shift-register and next-counter decode.
  always_comb begin
    state_nxt_s = state_r;
    shift_nxt_s = shift_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (xfer_s) begin
          state_nxt_s = SHIFT;
          shift_nxt_s = bus.par_data_i;
          cnt_nxt_s   = {CNT_W{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHIFT: begin
        if (last_s) begin
          if (xfer_s) begin
            // Reload on the last-bit edge: next word follows with no bubble.
            state_nxt_s = SHIFT;
            shift_nxt_s = bus.par_data_i;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end else begin
            state_nxt_s = IDLE;
            shift_nxt_s = shifted_s;
            cnt_nxt_s   = {CNT_W{1'b0}};
          end
        end else begin
          state_nxt_s = SHIFT;
          shift_nxt_s = shifted_s;
          cnt_nxt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        shift_nxt_s = {DATA_W{1'b0}};
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, data and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      shift_r <= {DATA_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      shift_r <= shift_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  assign bus.par_ready_o = ready_s;
  assign bus.ser_d_o     = (LSB_FIRST != 0) ? shift_r[0] : shift_r[DATA_W-1];
  assign bus.ser_en_o    = (state_r == SHIFT);
  assign bus.busy_o      = (state_r == SHIFT);
  assign bus.last_o      = last_s;

endmodule

// File: tb/tb_par2ser_en.sv
// tb_par2ser_en: self-checking bench for par2ser_en.
// Three instances: A (DATA_W=8, LSB first), B (DATA_W=8, MSB first),
// C (DATA_W=1). The reference model keeps, per instance, a queue of the bits
// still to be emitted: a handshake appends the word's bits in output order,
// every clock edge consumes the front bit. Outputs are predicted from the
// queue length and its front bit.
module tb_par2ser_en;

  logic clk;
  logic reset;

  par2ser_en_if #(.DATA_W(8)) if_a ();
  par2ser_en_if #(.DATA_W(8)) if_b ();
  par2ser_en_if #(.DATA_W(1)) if_c ();

  par2ser_en #(.DATA_W(8), .LSB_FIRST(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  par2ser_en #(.DATA_W(8), .LSB_FIRST(0)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
  par2ser_en #(.DATA_W(1), .LSB_FIRST(1)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit qa[$];
  bit qb[$];
  bit qc[$];

  // Expected {ready, d, en, last, busy} from a pending-bit count and front bit.
  function automatic logic [4:0] exp_of(input int n, input bit f);
    return {(n <= 1), ((n > 0) ? f : 1'b0), (n > 0), (n == 1), (n > 0)};
  endfunction

  function automatic logic [4:0] exp_a();
    return exp_of(qa.size(), (qa.size() > 0) ? qa[0] : 1'b0);
  endfunction
  function automatic logic [4:0] exp_b();
    return exp_of(qb.size(), (qb.size() > 0) ? qb[0] : 1'b0);
  endfunction
  function automatic logic [4:0] exp_c();
    return exp_of(qc.size(), (qc.size() > 0) ? qc[0] : 1'b0);
  endfunction

  // Advance the model across one rising edge using the inputs as driven.
  task automatic model_edge();
    bit ra, rb, rc;
    ra = (qa.size() <= 1);
    rb = (qb.size() <= 1);
    rc = (qc.size() <= 1);
    if (qa.size() > 0) void'(qa.pop_front());
    if (qb.size() > 0) void'(qb.pop_front());
    if (qc.size() > 0) void'(qc.pop_front());
    if (reset) begin
      if (if_a.par_valid_i && ra)
        for (int i = 0; i < 8; i++) qa.push_back(if_a.par_data_i[i]);
      if (if_b.par_valid_i && rb)
        for (int i = 7; i >= 0; i--) qb.push_back(if_b.par_data_i[i]);
      if (if_c.par_valid_i && rc)
        qc.push_back(if_c.par_data_i[0]);
    end else begin
      qa.delete();
      qb.delete();
      qc.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    reset = 1'b0;
    if_a.par_valid_i = 1'b0; if_a.par_data_i = 8'h00;
    if_b.par_valid_i = 1'b0; if_b.par_data_i = 8'h00;
    if_c.par_valid_i = 1'b0; if_c.par_data_i = 1'b0;
    // Inputs must be ignored while reset is low.
    @(negedge clk);
    if_a.par_valid_i = 1'b1; if_a.par_data_i = 8'hFF;
    tick();
    if_a.par_valid_i = 1'b0;
    obs = {if_a.par_ready_o, if_a.ser_d_o, if_a.ser_en_o, if_a.last_o, if_a.busy_o};
    n_checks++;
    if (obs !== 5'b10000) $display("FAIL reset_a: got %b want %b", obs, 5'b10000);
    else n_pass++;
    obs = {if_b.par_ready_o, if_b.ser_d_o, if_b.ser_en_o, if_b.last_o, if_b.busy_o};
    n_checks++;
    if (obs !== 5'b10000) $display("FAIL reset_b: got %b want %b", obs, 5'b10000);
    else n_pass++;
    obs = {if_c.par_ready_o, if_c.ser_d_o, if_c.ser_en_o, if_c.last_o, if_c.busy_o};
    n_checks++;
    if (obs !== 5'b10000) $display("FAIL reset_c: got %b want %b", obs, 5'b10000);
    else n_pass++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_a5();
    logic [4:0] obs;
    logic [7:0] got;
    got = 8'h00;
    if_a.par_valid_i = 1'b1; if_a.par_data_i = 8'hA5;
    tick();
    if_a.par_valid_i = 1'b0; if_a.par_data_i = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      obs = {if_a.par_ready_o, if_a.ser_d_o, if_a.ser_en_o, if_a.last_o, if_a.busy_o};
      n_checks++;
      if (obs !== exp_a()) $display("FAIL single_a5 cyc %0d: got %b want %b", c, obs, exp_a());
      else n_pass++;
      if (c <= 8) got = {if_a.ser_d_o, got[7:1]};
      tick();
    end
    n_checks++;
    if (got !== 8'hA5) $display("FAIL single_a5_word: got %h want %h", got, 8'hA5);
    else n_pass++;
  endtask

  task automatic test_bit_order();
    logic [4:0] obs;
    logic [7:0] got_a, got_b;
    got_a = 8'h00; got_b = 8'h00;
    if_a.par_valid_i = 1'b1; if_a.par_data_i = 8'h1F;
    if_b.par_valid_i = 1'b1; if_b.par_data_i = 8'h1F;
    tick();
    if_a.par_valid_i = 1'b0;
    if_b.par_valid_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      obs = {if_a.par_ready_o, if_a.ser_d_o, if_a.ser_en_o, if_a.last_o, if_a.busy_o};
      n_checks++;
      if (obs !== exp_a()) $display("FAIL order_lsb cyc %0d: got %b want %b", c, obs, exp_a());
      else n_pass++;
      obs = {if_b.par_ready_o, if_b.ser_d_o, if_b.ser_en_o, if_b.last_o, if_b.busy_o};
      n_checks++;
      if (obs !== exp_b()) $display("FAIL order_msb cyc %0d: got %b want %b", c, obs, exp_b());
      else n_pass++;
      if (c <= 8) begin
        got_a = {if_a.ser_d_o, got_a[7:1]};
        got_b = {got_b[6:0], if_b.ser_d_o};
      end
      tick();
    end
    // Stream order: LSB-first 1,1,1,1,1,0,0,0 and MSB-first 0,0,0,1,1,1,1,1.
    n_checks++;
    if (got_a !== 8'h1F) $display("FAIL order_lsb_word: got %h want %h", got_a, 8'h1F);
    else n_pass++;
    n_checks++;
    if (got_b !== 8'h1F) $display("FAIL order_msb_word: got %h want %h", got_b, 8'h1F);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  obs;
    logic [15:0] got;
    int          en_cnt;
    got = 16'h0000; en_cnt = 0;
    if_a.par_valid_i = 1'b1; if_a.par_data_i = 8'h0F;
    tick();
    if_a.par_data_i = 8'hF0;
    for (int c = 1; c <= 18; c++) begin
      obs = {if_a.par_ready_o, if_a.ser_d_o, if_a.ser_en_o, if_a.last_o, if_a.busy_o};
      n_checks++;
      if (obs !== exp_a()) $display("FAIL b2b cyc %0d: got %b want %b", c, obs, exp_a());
      else n_pass++;
      if (c <= 16) begin
        got = {if_a.ser_d_o, got[15:1]};
        if (if_a.ser_en_o) en_cnt++;
      end
      if (c == 8) begin
        n_checks++;
        if (if_a.par_ready_o !== 1'b1) $display("FAIL b2b_ready8: got %b want 1", if_a.par_ready_o);
        else n_pass++;
      end
      if (c == 9) if_a.par_valid_i = 1'b0;
      tick();
    end
    n_checks++;
    if (en_cnt != 16) $display("FAIL b2b_en_run: got %0d want 16", en_cnt);
    else n_pass++;
    n_checks++;
    if (got !== 16'hF00F) $display("FAIL b2b_bits: got %h want %h", got, 16'hF00F);
    else n_pass++;
  endtask

  task automatic test_valid_busy();
    logic [4:0] obs;
    logic [7:0] got;
    got = 8'h00;
    if_a.par_valid_i = 1'b1; if_a.par_data_i = 8'h00;
    tick();
    for (int c = 1; c <= 18; c++) begin
      obs = {if_a.par_ready_o, if_a.ser_d_o, if_a.ser_en_o, if_a.last_o, if_a.busy_o};
      n_checks++;
      if (obs !== exp_a()) $display("FAIL valid_busy cyc %0d: got %b want %b", c, obs, exp_a());
      else n_pass++;
      if (c >= 9 && c <= 16) got = {if_a.ser_d_o, got[7:1]};
      if (c == 1) if_a.par_valid_i = 1'b0;
      if (c >= 2 && c <= 6) begin
        if_a.par_valid_i = 1'b1;
        if_a.par_data_i  = 8'($urandom);
      end
      if (c == 7) if_a.par_data_i = 8'h55;
      if (c == 9) if_a.par_valid_i = 1'b0;
      tick();
    end
    n_checks++;
    if (got !== 8'h55) $display("FAIL valid_busy_word: got %h want %h", got, 8'h55);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    logic [2:0] flags;
    logic [7:0] got;
    got = 8'h00;
    if_a.par_valid_i = 1'b1; if_a.par_data_i = 8'hFF;
    tick();
    if_a.par_valid_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      obs = {if_a.par_ready_o, if_a.ser_d_o, if_a.ser_en_o, if_a.last_o, if_a.busy_o};
      n_checks++;
      if (obs !== exp_a()) $display("FAIL rst_mid_pre cyc %0d: got %b want %b", c, obs, exp_a());
      else n_pass++;
      tick();
    end
    // Pull reset between clock edges; outputs must drop without an edge.
    #2;
    reset = 1'b0;
    #1;
    flags = {if_a.ser_en_o, if_a.busy_o, if_a.last_o};
    n_checks++;
    if (flags !== 3'b000) $display("FAIL rst_mid_async: got en/busy/last %b want 000", flags);
    else n_pass++;
    qa.delete();
    @(negedge clk);
    reset = 1'b1;
    obs = {if_a.par_ready_o, if_a.ser_d_o, if_a.ser_en_o, if_a.last_o, if_a.busy_o};
    n_checks++;
    if (obs !== 5'b10000) $display("FAIL rst_mid_release: got %b want %b", obs, 5'b10000);
    else n_pass++;
    if_a.par_valid_i = 1'b1; if_a.par_data_i = 8'h81;
    tick();
    if_a.par_valid_i = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      obs = {if_a.par_ready_o, if_a.ser_d_o, if_a.ser_en_o, if_a.last_o, if_a.busy_o};
      n_checks++;
      if (obs !== exp_a()) $display("FAIL rst_mid_next cyc %0d: got %b want %b", c, obs, exp_a());
      else n_pass++;
      if (c <= 8) got = {if_a.ser_d_o, got[7:1]};
      tick();
    end
    n_checks++;
    if (got !== 8'h81) $display("FAIL rst_mid_word: got %h want %h", got, 8'h81);
    else n_pass++;
  endtask

  task automatic test_width1();
    logic [4:0] obs;
    logic [2:0] seq;
    seq = 3'b101;
    if_c.par_valid_i = 1'b1; if_c.par_data_i = 1'b1;
    tick();
    for (int c = 1; c <= 5; c++) begin
      obs = {if_c.par_ready_o, if_c.ser_d_o, if_c.ser_en_o, if_c.last_o, if_c.busy_o};
      n_checks++;
      if (obs !== exp_c()) $display("FAIL width1 cyc %0d: got %b want %b", c, obs, exp_c());
      else n_pass++;
      n_checks++;
      if (if_c.par_ready_o !== 1'b1) $display("FAIL width1_ready cyc %0d: got %b want 1", c, if_c.par_ready_o);
      else n_pass++;
      if (c <= 3) begin
        n_checks++;
        if ({if_c.ser_en_o, if_c.last_o, if_c.ser_d_o} !== {2'b11, seq[3-c]})
          $display("FAIL width1_bit cyc %0d: got %b want %b", c,
                   {if_c.ser_en_o, if_c.last_o, if_c.ser_d_o}, {2'b11, seq[3-c]});
        else n_pass++;
      end
      if (c == 1) if_c.par_data_i = 1'b0;
      if (c == 2) if_c.par_data_i = 1'b1;
      if (c == 3) if_c.par_valid_i = 1'b0;
      tick();
    end
  endtask

  task automatic test_random();
    logic [4:0] obs;
    for (int c = 0; c < 400; c++) begin
      obs = {if_a.par_ready_o, if_a.ser_d_o, if_a.ser_en_o, if_a.last_o, if_a.busy_o};
      n_checks++;
      if (obs !== exp_a()) $display("FAIL rand_a cyc %0d: got %b want %b", c, obs, exp_a());
      else n_pass++;
      obs = {if_b.par_ready_o, if_b.ser_d_o, if_b.ser_en_o, if_b.last_o, if_b.busy_o};
      n_checks++;
      if (obs !== exp_b()) $display("FAIL rand_b cyc %0d: got %b want %b", c, obs, exp_b());
      else n_pass++;
      obs = {if_c.par_ready_o, if_c.ser_d_o, if_c.ser_en_o, if_c.last_o, if_c.busy_o};
      n_checks++;
      if (obs !== exp_c()) $display("FAIL rand_c cyc %0d: got %b want %b", c, obs, exp_c());
      else n_pass++;
      if_a.par_valid_i = ($urandom_range(0, 3) != 0);
      if_a.par_data_i  = 8'($urandom);
      if_b.par_valid_i = ($urandom_range(0, 2) != 0);
      if_b.par_data_i  = 8'($urandom);
      if_c.par_valid_i = ($urandom_range(0, 1) != 0);
      if_c.par_data_i  = 1'($urandom);
      tick();
    end
    if_a.par_valid_i = 1'b0;
    if_b.par_valid_i = 1'b0;
    if_c.par_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_bit_order();
    test_back_to_back();
    test_valid_busy();
    test_reset_mid();
    test_width1();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
